// File: rtl/hh_weight_read_scheduler.sv
// Row-major read sequencer for one hidden-hidden gate weight memory, with host write arbitration.
// Optional stall-cycle counter output enabled by defining HH_SCHED_PERF_CNT_EN.
module hh_weight_read_scheduler #(
    parameter int ADDR_WIDTH    = 14,
    parameter int DATA_WIDTH    = 16,
    parameter int ROWS          = 128,
    parameter int WORDS_PER_ROW = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    stall,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_read_enable,
    output logic [ADDR_WIDTH-2:0]   mem_read_pointer,
    output logic                    word_valid,
    output logic [6:0]              row_index,
    output logic [5:0]              col_word_index,
    output logic                    row_first,
    output logic                    row_last,
    input  logic                    host_wr_req,
    input  logic [ADDR_WIDTH-2:0]   host_wr_addr,
    input  logic [2*DATA_WIDTH-1:0] host_wr_data,
    output logic                    host_wr_ready,
    output logic                    mem_write_enable,
    output logic [ADDR_WIDTH-2:0]   mem_write_address,
    output logic [2*DATA_WIDTH-1:0] mem_write_data
`ifdef HH_SCHED_PERF_CNT_EN
    ,
    output logic [15:0]             stall_cycles
`endif
);

    localparam int PW = ADDR_WIDTH - 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(ROWS * WORDS_PER_ROW - 1);
    localparam logic [5:0]    LAST_COL = 6'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          state, state_nxt;
    logic            issue, start_acc;
    logic [PW-1:0]   ptr_p0;
    logic [6:0]      row_p0;
    logic [5:0]      col_p0;
    logic            vld_p1, first_p1, last_p1;
    logic [6:0]      row_p1;
    logic [5:0]      col_p1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && !abort) state_nxt = S_RUN;
            S_RUN: begin
                if (abort)                           state_nxt = S_IDLE;
                else if (issue && ptr_p0 == LAST_PTR) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Host writes only win while idle and no sweep is starting in the same cycle.
    always_comb begin
        issue             = (state == S_RUN) && !stall;
        start_acc         = (state == S_IDLE) && start && !abort;
        busy              = (state != S_IDLE);
        done              = (state == S_DRAIN) && !abort;
        mem_read_enable   = issue;
        mem_read_pointer  = ptr_p0;
        host_wr_ready     = rst_n && (state == S_IDLE) && !start;
        mem_write_enable  = host_wr_req && host_wr_ready;
        mem_write_address = host_wr_addr;
        mem_write_data    = host_wr_data;
    end

    // Stage p0: issue pointer and row/column position of the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_p0 <= '0;
            row_p0 <= '0;
            col_p0 <= '0;
        end else if (start_acc) begin
            ptr_p0 <= '0;
            row_p0 <= '0;
            col_p0 <= '0;
        end else if (issue) begin
            ptr_p0 <= ptr_p0 + PW'(1);
            if (col_p0 == LAST_COL) begin
                col_p0 <= '0;
                row_p0 <= row_p0 + 7'd1;
            end else begin
                col_p0 <= col_p0 + 6'd1;
            end
        end
    end

    // Stage p1: tags aligned with the one-cycle memory read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            row_p1   <= '0;
            col_p1   <= '0;
        end else begin
            vld_p1   <= issue && !abort;
            first_p1 <= issue && !abort && (col_p0 == 6'd0);
            last_p1  <= issue && !abort && (col_p0 == LAST_COL);
            if (issue) begin
                row_p1 <= row_p0;
                col_p1 <= col_p0;
            end
        end
    end

    assign word_valid     = vld_p1;
    assign row_first      = first_p1;
    assign row_last       = last_p1;
    assign row_index      = row_p1;
    assign col_word_index = col_p1;

`ifdef HH_SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        stall_cycles <= '0;
        else if (start_acc)                stall_cycles <= '0;
        else if (state == S_RUN && stall)  stall_cycles <= sat_inc16(stall_cycles);
    end
`endif

endmodule
